multicycle_control_unit: RTL

//  Control FSM for the next-generation multi-cycle RV32I core; replaces the single-cycle Control_unit beside Datapath.

---
 rtl/multicycle_control_unit_if.sv | 32 +++
 rtl/multicycle_control_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Purpose  : Shared memory-port handshake between the multi-cycle control
//            unit (master) and the memory/datapath side (slave).
// Signals  : mem_ready - memory completes the current read/write this cycle
//            IorD      - 0 = address from PC, 1 = address from ALU result
//            MemRead   - memory read request
//            MemWrite  - memory write request
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
  logic mem_ready;
  logic IorD;
  logic MemRead;
  logic MemWrite;

  modport master (
    input  mem_ready,
    output IorD,
    output MemRead,
    output MemWrite
  );

  modport slave (
    output mem_ready,
    input  IorD,
    input  MemRead,
    input  MemWrite
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Control FSM for the multi-cycle RV32I core. Sequences each
//            instruction through FETCH/DECODE/EXEC/MEM/WB over one shared
//            memory port with a ready handshake, and emits the datapath
//            control set plus sequencing strobes.
// Params   : MEM_TIMEOUT - max wait cycles on mem_ready in FETCH/MEM before
//                          bus_error (0 = never time out)
// Macro    : MULTICYCLE_PERF_EN - adds cycle_count / instret_count ports
// Ports    : clk, reset        - clock, synchronous active-high reset
//            Opcode, funct3    - instruction fields from the IR
//            mem_bus (master)  - mem_ready / IorD / MemRead / MemWrite
//            IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, ALUOp[1:0]
//            BEQ..BGEU, JAL, JALR - branch / jump selects
//            instr_done        - one-cycle retirement pulse
//            illegal_instr     - sticky unsupported-instruction flag
//            bus_error         - sticky memory-timeout flag
//            state[2:0]        - 0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,5 HALT
//            cycle_count, instret_count (MULTICYCLE_PERF_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [6:0]                        Opcode,
  input  logic [2:0]                        funct3,
  multicycle_control_unit_if.master         mem_bus,
  output logic                              IRWrite,
  output logic                              PCWrite,
  output logic                              ALUSrc,
  output logic                              MemtoReg,
  output logic                              RegWrite,
  output logic [1:0]                        ALUOp,
  output logic                              BEQ,
  output logic                              BNE,
  output logic                              BLT,
  output logic                              BGE,
  output logic                              BLTU,
  output logic                              BGEU,
  output logic                              JAL,
  output logic                              JALR,
  output logic                              instr_done,
  output logic                              illegal_instr,
  output logic                              bus_error,
  output logic [2:0]                        state
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]                       cycle_count,
  output logic [31:0]                       instret_count
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_opc_r      = 7'b0110011;
  localparam logic [6:0] c_opc_i_alu  = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;

  // Counter wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Moore part of the control set; br is {BEQ,BNE,BLT,BGE,BLTU,BGEU}.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       instr_done;
    logic [1:0] alu_op;
    logic [5:0] br;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  // --------------------------------------------------------------------------
  // Decode helpers
  // --------------------------------------------------------------------------
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      c_opc_r, c_opc_i_alu, c_opc_load, c_opc_store,
      c_opc_jal, c_opc_jalr, c_opc_lui, c_opc_auipc: ok = 1'b1;
      c_opc_branch: ok = (f3 != 3'b010) && (f3 != 3'b011);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Control set for a given state; FETCH/DECODE do not look at op/f3.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [6:0] op,
                                        input logic [2:0] f3);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.mem_read = 1'b1;
      S_EXEC: begin
        case (op)
          c_opc_load, c_opc_store, c_opc_jalr, c_opc_lui, c_opc_auipc: begin
            c.alu_op  = 2'b00;
            c.alu_src = 1'b1;
          end
          c_opc_i_alu: begin
            c.alu_op  = 2'b11;
            c.alu_src = 1'b1;
          end
          c_opc_r: c.alu_op = 2'b10;
          c_opc_branch: begin
            c.alu_op     = 2'b01;
            c.pc_write   = 1'b1;
            c.instr_done = 1'b1;
            case (f3)
              3'b000:  c.br = 6'b100000;
              3'b001:  c.br = 6'b010000;
              3'b100:  c.br = 6'b001000;
              3'b101:  c.br = 6'b000100;
              3'b110:  c.br = 6'b000010;
              3'b111:  c.br = 6'b000001;
              default: c.br = 6'b000000;
            endcase
          end
          default: c.alu_op = 2'b00;
        endcase
        c.jal  = (op == c_opc_jal);
        c.jalr = (op == c_opc_jalr);
      end
      S_MEM: begin
        c.iord      = 1'b1;
        c.mem_read  = (op == c_opc_load);
        c.mem_write = (op == c_opc_store);
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (op == c_opc_load);
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
        c.jal        = (op == c_opc_jal);
        c.jalr       = (op == c_opc_jalr);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [6:0]          opc_q, opc_d;
  logic [2:0]          f3_q, f3_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  ctrl_t               ctrl_q, ctrl_d;

  logic                w_timeout;
  logic                w_store_done;
  logic                w_instr_done;

  // mem_ready in the same cycle as the limit wins over the timeout.
  assign w_timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT)) &&
                     !mem_bus.mem_ready;

  // Store completion is the only retirement that depends on the handshake.
  assign w_store_done = (state_q == S_MEM) && (opc_q == c_opc_store) &&
                        mem_bus.mem_ready;
  assign w_instr_done = ctrl_q.instr_done || w_store_done;

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    f3_d      = f3_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;

    case (state_q)
      S_FETCH: begin
        if (mem_bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (w_timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        opc_d = Opcode;
        f3_d  = funct3;
        if (is_legal(Opcode, funct3)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (opc_q == c_opc_branch) begin
          state_d = S_FETCH;
        end else if ((opc_q == c_opc_load) || (opc_q == c_opc_store)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_bus.mem_ready) begin
          state_d = (opc_q == c_opc_store) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Every memory-waiting state starts its wait budget from zero.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end

    // Outputs are registered: decode the state being entered.
    ctrl_d = ctrl_decode(state_d, opc_d, f3_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      f3_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      ctrl_q    <= ctrl_decode(S_FETCH, 7'd0, 3'd0);
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      f3_q      <= f3_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all held at zero while reset is asserted
  // --------------------------------------------------------------------------
  always_comb begin
    mem_bus.IorD     = 1'b0;
    mem_bus.MemRead  = 1'b0;
    mem_bus.MemWrite = 1'b0;
    IRWrite          = 1'b0;
    PCWrite          = 1'b0;
    ALUSrc           = 1'b0;
    MemtoReg         = 1'b0;
    RegWrite         = 1'b0;
    ALUOp            = 2'b00;
    {BEQ, BNE, BLT, BGE, BLTU, BGEU} = 6'b000000;
    JAL              = 1'b0;
    JALR             = 1'b0;
    instr_done       = 1'b0;
    illegal_instr    = 1'b0;
    bus_error        = 1'b0;
    state            = 3'd0;
    if (!reset) begin
      mem_bus.IorD     = ctrl_q.iord;
      mem_bus.MemRead  = ctrl_q.mem_read;
      mem_bus.MemWrite = ctrl_q.mem_write;
      IRWrite          = (state_q == S_FETCH) && mem_bus.mem_ready;
      PCWrite          = ctrl_q.pc_write || w_store_done;
      ALUSrc           = ctrl_q.alu_src;
      MemtoReg         = ctrl_q.mem_to_reg;
      RegWrite         = ctrl_q.reg_write;
      ALUOp            = ctrl_q.alu_op;
      {BEQ, BNE, BLT, BGE, BLTU, BGEU} = ctrl_q.br;
      JAL              = ctrl_q.jal;
      JALR             = ctrl_q.jalr;
      instr_done       = w_instr_done;
      illegal_instr    = illegal_q;
      bus_error        = bus_err_q;
      state            = state_q;
    end
  end

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (state_q != S_HALT) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
    if (w_instr_done) begin
      ret_cnt_d = ret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cycle_count   = reset ? 32'd0 : cyc_cnt_q;
  assign instret_count = reset ? 32'd0 : ret_cnt_q;
`else
  // Counters are not built; nothing else depends on them.
`endif

endmodule
`default_nettype wire
